// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the fetch-stage program-counter generator.
// Imported by pc_gen and its next-PC selector.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_ERET,
    SRC_EXC
  } redirect_src_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

  function automatic logic is_redirect(input redirect_src_t src);
    return src != SRC_SEQ;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: fixed-priority redirect mux with target alignment check.
// Produces the next PC, the EPC load value/enable and the misalignment flag.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int                 WIDTH       = 32,
  parameter int                 INSTR_BYTES = 4,
  parameter logic [WIDTH-1:0]   EXC_VECTOR  = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input  pc_state_t         state,
  input  logic              en,
  input  logic              if_ready,
  input  logic              exc,
  input  logic              eret,
  input  logic              jmp,
  input  logic              br_taken,
  input  logic [WIDTH-1:0]  exc_pc,
  input  logic [WIDTH-1:0]  epc,
  input  logic [WIDTH-1:0]  jmp_target,
  input  logic [WIDTH-1:0]  br_target,
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  pc_plus,
  output logic [WIDTH-1:0]  next_pc,
  output logic [WIDTH-1:0]  epc_next,
  output logic              epc_load,
  output logic              misaligned,
  output logic              redirect
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

  redirect_src_t    src;
  logic [WIDTH-1:0] target;

  // Only exceptions and exception returns can wake the PC out of HALT.
  always_comb begin
    src = SRC_SEQ;
    if (state != BOOT) begin
      if (exc)
        src = SRC_EXC;
      else if (eret)
        src = SRC_ERET;
      else if (state == RUN && jmp)
        src = SRC_JMP;
      else if (state == RUN && br_taken)
        src = SRC_BR;
    end
  end

  always_comb begin
    target = '0;
    case (src)
      SRC_ERET: target = epc;
      SRC_JMP:  target = jmp_target;
      SRC_BR:   target = br_target;
      default:  target = '0;
    endcase
  end

  assign misaligned = (src inside {SRC_ERET, SRC_JMP, SRC_BR}) && (|(target & ALIGN_MASK));
  assign redirect   = is_redirect(src);

  // A misaligned target traps like an exception, recording the bad target as EPC.
  always_comb begin
    next_pc  = pc;
    epc_next = target;
    epc_load = 1'b0;
    if (src == SRC_EXC) begin
      next_pc  = EXC_VECTOR;
      epc_next = exc_pc;
      epc_load = 1'b1;
    end else if (misaligned) begin
      next_pc  = EXC_VECTOR;
      epc_load = 1'b1;
    end else if (redirect) begin
      next_pc  = target;
    end else if (state == RUN && en && if_ready) begin
      next_pc  = pc_plus;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the MIPS fetch stage: holds PC, EPC and the
// boot/run/halt state, and presents the fetch address over a valid/ready handshake.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                 WIDTH        = 32,
  parameter int                 INSTR_BYTES  = 4,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              if_ready,
  input  logic              br_taken,
  input  logic [WIDTH-1:0]  br_target,
  input  logic              jmp,
  input  logic [WIDTH-1:0]  jmp_target,
  input  logic              exc,
  input  logic [WIDTH-1:0]  exc_pc,
  input  logic              eret,
  input  logic              halt,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  pc_plus,
  output logic              if_valid,
  output logic              if_kill,
  output logic [WIDTH-1:0]  epc,
  output logic              addr_err
);

  pc_state_t        state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic             addr_err_q;

  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] epc_next;
  logic             epc_load;
  logic             misaligned;
  logic             redirect;

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign addr_err = addr_err_q;
  assign pc_plus  = pc_q + WIDTH'(INSTR_BYTES);
  assign if_valid = (state_q == RUN);
  assign if_kill  = redirect && if_valid;

  pc_next_sel #(
    .WIDTH       (WIDTH),
    .INSTR_BYTES (INSTR_BYTES),
    .EXC_VECTOR  (EXC_VECTOR)
  ) u_next_sel (
    .state      (state_q),
    .en         (en),
    .if_ready   (if_ready),
    .exc        (exc),
    .eret       (eret),
    .jmp        (jmp),
    .br_taken   (br_taken),
    .exc_pc     (exc_pc),
    .epc        (epc_q),
    .jmp_target (jmp_target),
    .br_target  (br_target),
    .pc         (pc_q),
    .pc_plus    (pc_plus),
    .next_pc    (next_pc),
    .epc_next   (epc_next),
    .epc_load   (epc_load),
    .misaligned (misaligned),
    .redirect   (redirect)
  );

  // A halt request loses to any redirect taken in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      addr_err_q <= misaligned;
      if (epc_load)
        epc_q <= epc_next;
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt && !redirect) state_q <= HALT;
        HALT:    if (redirect) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch PC.
module tb_pc_gen;

  localparam logic [31:0] EXC_VEC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst, en, if_ready, br_taken, jmp, exc, eret, halt;
  logic [31:0] br_target, jmp_target, exc_pc;
  logic [31:0] pc, pc_plus, epc;
  logic        if_valid, if_kill, addr_err;

  logic        rst16;
  logic [15:0] br_target16, jmp_target16, exc_pc16;
  logic [15:0] pc16, pc_plus16, epc16;
  logic        if_valid16, if_kill16, addr_err16;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: boot/halt flags, PC, EPC and the expected error pulse.
  bit          m_boot, m_halt, x_halt;
  logic [31:0] m_pc, m_epc, x_pc, x_epc;
  logic        m_aerr, x_aerr, exp_kill, exp_valid;

  pc_gen dut (
    .clk(clk), .rst(rst), .en(en), .if_ready(if_ready),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .exc(exc), .exc_pc(exc_pc), .eret(eret), .halt(halt),
    .pc(pc), .pc_plus(pc_plus), .if_valid(if_valid), .if_kill(if_kill),
    .epc(epc), .addr_err(addr_err)
  );

  pc_gen #(.WIDTH(16), .INSTR_BYTES(4), .RESET_VECTOR(16'h0000), .EXC_VECTOR(16'h0180)) dut16 (
    .clk(clk), .rst(rst16), .en(en), .if_ready(if_ready),
    .br_taken(br_taken), .br_target(br_target16), .jmp(jmp), .jmp_target(jmp_target16),
    .exc(exc), .exc_pc(exc_pc16), .eret(eret), .halt(halt),
    .pc(pc16), .pc_plus(pc_plus16), .if_valid(if_valid16), .if_kill(if_kill16),
    .epc(epc16), .addr_err(addr_err16)
  );

  always #5 clk = ~clk;

  task automatic idle();
    en = 1; if_ready = 1; br_taken = 0; jmp = 0; exc = 0; eret = 0; halt = 0;
    br_target = 0; jmp_target = 0; exc_pc = 0;
    br_target16 = 0; jmp_target16 = 0; exc_pc16 = 0;
  endtask

  task automatic model_reset();
    m_boot = 1; m_halt = 0; m_pc = 0; m_epc = 0; m_aerr = 0;
  endtask

  task automatic model_eval();
    logic redir, chk;
    logic [31:0] tgt;
    redir = 0; chk = 0; tgt = 0;
    x_pc = m_pc; x_epc = m_epc; x_aerr = 0; x_halt = m_halt;
    if (!m_boot) begin
      if (exc) begin
        redir = 1; x_pc = EXC_VEC; x_epc = exc_pc;
      end else if (eret) begin
        redir = 1; chk = 1; tgt = m_epc;
      end else if (!m_halt && jmp) begin
        redir = 1; chk = 1; tgt = jmp_target;
      end else if (!m_halt && br_taken) begin
        redir = 1; chk = 1; tgt = br_target;
      end
      if (chk) begin
        if (tgt % 4 != 0) begin
          x_pc = EXC_VEC; x_epc = tgt; x_aerr = 1;
        end else begin
          x_pc = tgt;
        end
      end else if (!redir && !m_halt && en && if_ready) begin
        x_pc = m_pc + 32'd4;
      end
      if (m_halt && redir) x_halt = 0;
      else if (!m_halt && halt && !redir) x_halt = 1;
    end
    exp_valid = !m_boot && !m_halt;
    exp_kill  = redir && exp_valid;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    m_pc = x_pc; m_epc = x_epc; m_aerr = x_aerr; m_halt = x_halt; m_boot = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 0; rst16 = 0; idle(); model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    n_tests++; if (epc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
    n_tests++; if (if_valid !== 1'b0 || if_kill !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags got=%b%b%b exp=000", if_valid, if_kill, addr_err);
    end
    n_tests++; if (pc_plus !== 32'h4) begin n_fail++; $display("[TB] FAIL reset_pc_plus got=%h exp=%h", pc_plus, 32'h4); end
    rst = 1;
    #1;
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_valid got=%b exp=0", if_valid); end
    tick();
    n_tests++; if (pc !== 32'h0 || if_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL first_fetch got pc=%h valid=%b exp pc=0 valid=1", pc, if_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); tick();
      n_tests++; if (pc !== 32'(4 * i)) begin n_fail++; $display("[TB] FAIL seq_pc got=%h exp=%h", pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_stall();
    @(negedge clk); tick();
    n_tests++; if (pc !== 32'h10) begin n_fail++; $display("[TB] FAIL stall_start got=%h exp=%h", pc, 32'h10); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); en = 0; tick();
      n_tests++; if (pc !== 32'h10) begin n_fail++; $display("[TB] FAIL stall_hold got=%h exp=%h", pc, 32'h10); end
    end
    @(negedge clk); br_taken = 1; br_target = 32'h40; #1;
    n_tests++; if (if_kill !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_kill got=%b exp=1", if_kill); end
    tick();
    n_tests++; if (pc !== 32'h40) begin n_fail++; $display("[TB] FAIL stall_branch got=%h exp=%h", pc, 32'h40); end
    @(negedge clk); idle();
  endtask

  task automatic test_priority();
    exc = 1; exc_pc = 32'h24; jmp = 1; jmp_target = 32'h200; br_taken = 1; br_target = 32'h300; #1;
    n_tests++; if (if_kill !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_kill got=%b exp=1", if_kill); end
    tick();
    n_tests++; if (pc !== EXC_VEC || epc !== 32'h24) begin
      n_fail++; $display("[TB] FAIL prio_exc got pc=%h epc=%h exp pc=%h epc=%h", pc, epc, EXC_VEC, 32'h24);
    end
    @(negedge clk); idle(); eret = 1; tick();
    n_tests++; if (pc !== 32'h24) begin n_fail++; $display("[TB] FAIL prio_eret got=%h exp=%h", pc, 32'h24); end
    @(negedge clk); idle();
  endtask

  task automatic test_misaligned();
    jmp = 1; jmp_target = 32'h102; #1;
    n_tests++; if (if_kill !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_kill got=%b exp=1", if_kill); end
    tick();
    n_tests++; if (pc !== EXC_VEC || epc !== 32'h102 || addr_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mis_trap got pc=%h epc=%h err=%b exp pc=%h epc=102 err=1", pc, epc, addr_err, EXC_VEC);
    end
    @(negedge clk); idle(); tick();
    n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_pulse got=%b exp=0", addr_err); end
    @(negedge clk); idle();
  endtask

  task automatic test_halt();
    exc = 1; exc_pc = 32'h60; tick();
    @(negedge clk); idle(); jmp = 1; jmp_target = 32'h50; tick();
    @(negedge clk); idle(); halt = 1; en = 0; tick();
    n_tests++; if (if_valid !== 1'b0 || pc !== 32'h50) begin
      n_fail++; $display("[TB] FAIL halt_enter got valid=%b pc=%h exp valid=0 pc=50", if_valid, pc);
    end
    @(negedge clk); idle(); br_taken = 1; br_target = 32'h90; tick();
    n_tests++; if (pc !== 32'h50 || if_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL halt_hold got pc=%h valid=%b exp pc=50 valid=0", pc, if_valid);
    end
    @(negedge clk); idle(); eret = 1; tick();
    n_tests++; if (pc !== 32'h60 || if_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL halt_eret got pc=%h valid=%b exp pc=60 valid=1", pc, if_valid);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if_ready = ($urandom_range(0, 3) != 0);
      exc = ($urandom_range(0, 15) == 0);
      eret = ($urandom_range(0, 15) == 0);
      jmp = ($urandom_range(0, 7) == 0);
      br_taken = ($urandom_range(0, 5) == 0);
      halt = ($urandom_range(0, 11) == 0);
      exc_pc = $urandom & ~32'h3;
      jmp_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'h3);
      br_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'h3);
      #1; model_eval();
      n_tests++; if (if_valid !== exp_valid || if_kill !== exp_kill || pc_plus !== m_pc + 32'd4) begin
        n_fail++; $display("[TB] FAIL rand_comb got valid=%b kill=%b plus=%h exp valid=%b kill=%b plus=%h",
                           if_valid, if_kill, pc_plus, exp_valid, exp_kill, m_pc + 32'd4);
      end
      tick();
      n_tests++; if (pc !== m_pc || epc !== m_epc || addr_err !== m_aerr) begin
        n_fail++; $display("[TB] FAIL rand_state got pc=%h epc=%h err=%b exp pc=%h epc=%h err=%b",
                           pc, epc, addr_err, m_pc, m_epc, m_aerr);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_async_reset();
    exc = 1; exc_pc = 32'h44; tick();
    @(negedge clk); idle(); #2; rst = 0; #1;
    n_tests++; if (pc !== 32'h0 || epc !== 32'h0 || if_valid !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_reset got pc=%h epc=%h valid=%b err=%b exp all zero", pc, epc, if_valid, addr_err);
    end
    model_reset();
    @(negedge clk); rst = 1;
  endtask

  task automatic test_wrap16();
    idle(); rst16 = 1;
    @(posedge clk); #1;
    @(negedge clk); jmp = 1; jmp_target16 = 16'hFFFC;
    @(posedge clk); #1;
    n_tests++; if (pc16 !== 16'hFFFC) begin n_fail++; $display("[TB] FAIL w16_jump got=%h exp=FFFC", pc16); end
    @(negedge clk); idle(); #1;
    n_tests++; if (pc_plus16 !== 16'h0000) begin n_fail++; $display("[TB] FAIL w16_plus got=%h exp=0000", pc_plus16); end
    @(posedge clk); #1;
    n_tests++; if (pc16 !== 16'h0000 || addr_err16 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL w16_wrap got pc=%h err=%b exp pc=0000 err=0", pc16, addr_err16);
    end
    @(posedge clk); #1;
    @(negedge clk); #2; rst16 = 0; #1;
    n_tests++; if (pc16 !== 16'h0000 || if_valid16 !== 1'b0 || pc_plus16 !== 16'h0004 || if_kill16 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL w16_async got pc=%h valid=%b plus=%h kill=%b exp pc=0000 valid=0 plus=0004 kill=0",
                         pc16, if_valid16, pc_plus16, if_kill16);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_misaligned();
    test_halt();
    test_random();
    test_async_reset();
    test_wrap16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
